// File: rtl/rcv_byte_writer.sv
// rtl/rcv_byte_writer.sv - USB RX byte to FIFO enqueue stage with lane/length tracking and rollback
module rcv_byte_writer #(
    parameter int MAX_BYTES = 64,
    parameter int CNT_W     = 7
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             rx_start,
    input  logic             byte_received,
    input  logic [7:0]       rx_data,
    input  logic             rx_eop,
    input  logic             rx_error,
    input  logic             full,
    output logic             rcv_enq_word,
    output logic [7:0]       wr_data,
    output logic [1:0]       tail_side,
    output logic             fix_error,
    output logic             pkt_done,
    output logic [CNT_W-1:0] pkt_len,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t state;

    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_BYTES);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            rcv_enq_word <= 1'b0;
            wr_data      <= 8'd0;
            tail_side    <= 2'd0;
            fix_error    <= 1'b0;
            pkt_done     <= 1'b0;
            pkt_len      <= '0;
            overflow     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            rcv_enq_word <= 1'b0;
            fix_error    <= 1'b0;
            pkt_done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_start) begin
                        state     <= RECV;
                        busy      <= 1'b1;
                        pkt_len   <= '0;
                        tail_side <= 2'd0;
                        overflow  <= 1'b0;
                    end
                end
                RECV: begin
                    // Any dropped or aborted byte rolls the FIFO back; counters clear on entry to ERR
                    if (rx_error || rx_start ||
                        (byte_received && (full || pkt_len == LEN_MAX))) begin
                        state     <= ERR;
                        fix_error <= 1'b1;
                        pkt_len   <= '0;
                        tail_side <= 2'd0;
                        if (!rx_error && !rx_start && full)
                            overflow <= 1'b1;
                    end else begin
                        if (byte_received) begin
                            rcv_enq_word <= 1'b1;
                            wr_data      <= rx_data;
                            pkt_len      <= pkt_len + 1'b1;
                            tail_side    <= tail_side + 2'd1;
                        end
                        if (rx_eop) begin
                            state    <= DONE;
                            pkt_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rcv_byte_writer.sv
// tb/tb_rcv_byte_writer.sv - directed table-driven bench for rcv_byte_writer
module tb_rcv_byte_writer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       rx_start, byte_received, rx_eop, rx_error, full;
    logic [7:0] rx_data;
    logic       rcv_enq_word, fix_error, pkt_done, overflow, busy;
    logic [7:0] wr_data;
    logic [1:0] tail_side;
    logic [6:0] pkt_len;

    int errors = 0;
    int checks = 0;

    rcv_byte_writer #(.MAX_BYTES(64), .CNT_W(7)) dut (
        .clk(clk), .n_rst(n_rst), .rx_start(rx_start), .byte_received(byte_received),
        .rx_data(rx_data), .rx_eop(rx_eop), .rx_error(rx_error), .full(full),
        .rcv_enq_word(rcv_enq_word), .wr_data(wr_data), .tail_side(tail_side),
        .fix_error(fix_error), .pkt_done(pkt_done), .pkt_len(pkt_len),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st, br, eop, err, fl;
        logic [7:0] d;
        logic       enq;
        logic [7:0] wd;
        logic [1:0] tail;
        logic       fix, done;
        logic [6:0] len;
        logic       ovf, bsy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int st, br, d, eop, err, fl,
                                input int enq, wd, tail, fix, done, len, ovf, bsy);
        vec_t v;
        v.st = st[0]; v.br = br[0]; v.d = d[7:0]; v.eop = eop[0]; v.err = err[0]; v.fl = fl[0];
        v.enq = enq[0]; v.wd = wd[7:0]; v.tail = tail[1:0]; v.fix = fix[0]; v.done = done[0];
        v.len = len[6:0]; v.ovf = ovf[0]; v.bsy = bsy[0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, br, input logic [7:0] d, input logic eop, err, fl);
        rx_start = st; byte_received = br; rx_data = d; rx_eop = eop; rx_error = err; full = fl;
    endtask

    task automatic expect_out(input string tag, input logic enq, input logic [7:0] wd,
                              input logic [1:0] tail, input logic fix, done,
                              input logic [6:0] len, input logic ovf, bsy);
        chk({tag, ".enq"},  32'(rcv_enq_word), 32'(enq));
        chk({tag, ".wd"},   32'(wr_data),      32'(wd));
        chk({tag, ".tail"}, 32'(tail_side),    32'(tail));
        chk({tag, ".fix"},  32'(fix_error),    32'(fix));
        chk({tag, ".done"}, 32'(pkt_done),     32'(done));
        chk({tag, ".len"},  32'(pkt_len),      32'(len));
        chk({tag, ".ovf"},  32'(overflow),     32'(ovf));
        chk({tag, ".busy"}, 32'(busy),         32'(bsy));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // clean packet 0x11..0x15
        tbl.push_back(mk(1,0,0,0,0,0,       0,'h00,0,0,0,0,0,1));
        tbl.push_back(mk(0,1,'h11,0,0,0,    1,'h11,1,0,0,1,0,1));
        tbl.push_back(mk(0,1,'h12,0,0,0,    1,'h12,2,0,0,2,0,1));
        tbl.push_back(mk(0,1,'h13,0,0,0,    1,'h13,3,0,0,3,0,1));
        tbl.push_back(mk(0,1,'h14,0,0,0,    1,'h14,0,0,0,4,0,1));
        tbl.push_back(mk(0,1,'h15,0,0,0,    1,'h15,1,0,0,5,0,1));
        tbl.push_back(mk(0,0,0,1,0,0,       0,'h15,1,0,1,5,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,       0,'h15,1,0,0,5,0,0));
        // idle noise
        tbl.push_back(mk(0,1,'hAA,1,0,0,    0,'h15,1,0,0,5,0,0));
        tbl.push_back(mk(0,0,0,1,1,0,       0,'h15,1,0,0,5,0,0));
        // zero-length packet
        tbl.push_back(mk(1,0,0,0,0,0,       0,'h15,0,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,1,0,0,       0,'h15,0,0,1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,       0,'h15,0,0,0,0,0,0));
        // byte together with eop
        tbl.push_back(mk(1,0,0,0,0,0,       0,'h15,0,0,0,0,0,1));
        tbl.push_back(mk(0,1,'h21,0,0,0,    1,'h21,1,0,0,1,0,1));
        tbl.push_back(mk(0,1,'h22,1,0,0,    1,'h22,2,0,1,2,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,       0,'h22,2,0,0,2,0,0));
        // byte together with error
        tbl.push_back(mk(1,0,0,0,0,0,       0,'h22,0,0,0,0,0,1));
        tbl.push_back(mk(0,1,'h31,0,0,0,    1,'h31,1,0,0,1,0,1));
        tbl.push_back(mk(0,1,'h32,0,1,0,    0,'h31,0,1,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,       0,'h31,0,0,0,0,0,0));
        // abort by rx_start, then rx_start during ERR is ignored
        tbl.push_back(mk(1,0,0,0,0,0,       0,'h31,0,0,0,0,0,1));
        tbl.push_back(mk(0,1,'h41,0,0,0,    1,'h41,1,0,0,1,0,1));
        tbl.push_back(mk(0,1,'h42,0,0,0,    1,'h42,2,0,0,2,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,       0,'h42,0,1,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,       0,'h42,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,       0,'h42,0,0,0,0,0,0));
        // overflow, sticky until next rx_start
        tbl.push_back(mk(1,0,0,0,0,0,       0,'h42,0,0,0,0,0,1));
        tbl.push_back(mk(0,1,'h51,0,0,0,    1,'h51,1,0,0,1,0,1));
        tbl.push_back(mk(0,1,'h52,0,0,0,    1,'h52,2,0,0,2,0,1));
        tbl.push_back(mk(0,1,'h53,0,0,0,    1,'h53,3,0,0,3,0,1));
        tbl.push_back(mk(0,1,'h54,0,0,1,    0,'h53,0,1,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,0,       0,'h53,0,0,0,0,1,0));
        tbl.push_back(mk(0,1,'h60,0,0,1,    0,'h53,0,0,0,0,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,       0,'h53,0,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,1,0,0,       0,'h53,0,0,1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,       0,'h53,0,0,0,0,0,0));

        drive(0, 0, 8'h00, 0, 0, 0);
        n_rst = 1'b0;
        step();
        step();
        expect_out("reset", 0, 8'h00, 0, 0, 0, 7'd0, 0, 0);
        n_rst = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].br, tbl[i].d, tbl[i].eop, tbl[i].err, tbl[i].fl);
            step();
            expect_out($sformatf("v%0d", i), tbl[i].enq, tbl[i].wd, tbl[i].tail,
                       tbl[i].fix, tbl[i].done, tbl[i].len, tbl[i].ovf, tbl[i].bsy);
        end

        // 64 bytes fill the packet; the 65th is dropped and rolls back
        drive(1, 0, 8'h00, 0, 0, 0);
        step();
        for (int k = 1; k <= 64; k++) begin
            drive(0, 1, 8'(k), 0, 0, 0);
            step();
            expect_out($sformatf("len%0d", k), 1, 8'(k), 2'(k % 4), 0, 0, 7'(k), 0, 1);
        end
        drive(0, 1, 8'hEE, 0, 0, 0);
        step();
        expect_out("len65", 0, 8'd64, 0, 1, 0, 7'd0, 0, 1);
        drive(0, 0, 8'h00, 0, 0, 0);
        step();
        expect_out("len65_idle", 0, 8'd64, 0, 0, 0, 7'd0, 0, 0);

        // asynchronous reset mid-packet
        drive(1, 0, 8'h00, 0, 0, 0);
        step();
        drive(0, 1, 8'h71, 0, 0, 0);
        step();
        drive(0, 1, 8'h72, 0, 0, 0);
        step();
        expect_out("pre_rst", 1, 8'h72, 2, 0, 0, 7'd2, 0, 1);
        drive(0, 0, 8'h00, 0, 0, 0);
        #2 n_rst = 1'b0;
        #1;
        expect_out("async_rst", 0, 8'h00, 0, 0, 0, 7'd0, 0, 0);
        step();
        n_rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            expect_out($sformatf("post_rst%0d", k), 0, 8'h00, 0, 0, 0, 7'd0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rcv_byte_writer.md
# rcv_byte_writer

Receive-path stage between the USB RX byte decoder and the receive FIFO controller. Accepts one decoded byte per strobe and issues one registered FIFO enqueue per byte with the byte's lane within the 32-bit FIFO word. Tracks packet length and lane position. On a bad or aborted packet, issues a one-cycle rollback pulse to the FIFO so partial packet data is discarded.

## Interface
- MAX_BYTES, 64: maximum accepted payload bytes per packet.
- CNT_W, 7: width of the byte counter; must hold MAX_BYTES.

- clk  in  1  system clock, all logic on posedge.
- n_rst  in  1  asynchronous, active-low reset.
- rx_start  in  1  one-cycle strobe at the start of a packet.
- byte_received  in  1  one-cycle strobe; rx_data is valid.
- rx_data  in  8  decoded byte.
- rx_eop  in  1  one-cycle end-of-packet strobe.
- rx_error  in  1  one-cycle decoder error strobe (bit stuff, sync, PID).
- full  in  1  receive FIFO full.
- rcv_enq_word  out  1  one-cycle enqueue request to the FIFO.
- wr_data  out  8  byte being enqueued; valid with rcv_enq_word.
- tail_side  out  2  lane of the next byte to be written, 0..3.
- fix_error  out  1  one-cycle rollback/clear request to the FIFO.
- pkt_done  out  1  one-cycle strobe when a packet completes cleanly.
- pkt_len  out  CNT_W  bytes accepted in the current or last packet.
- overflow  out  1  sticky: a byte arrived while full was high.
- busy  out  1  high in every state except IDLE.

## Operation
- All outputs are registered. Every output resets to 0.
- States: IDLE, RECV, DONE, ERR. The reset state is IDLE.
- IDLE:
  - rx_start -> RECV. Clear pkt_len, tail_side and overflow.
  - byte_received, rx_eop and rx_error are ignored.
- RECV priority, from highest to lowest:
  1. rx_error or rx_start (abort) -> ERR.
  2. byte_received with full=1 -> set overflow, drop the byte, -> ERR.
  3. byte_received with pkt_len==MAX_BYTES -> drop the byte, -> ERR.
  4. byte_received otherwise -> accept the byte: rcv_enq_word=1 next cycle, wr_data=rx_data, pkt_len+1, tail_side+1 modulo 4 (3 wraps to 0).
  5. rx_eop -> DONE. rx_eop in the same cycle as an accepted byte: the byte is enqueued and counted, then DONE.
- DONE: pkt_done=1 for one cycle, then IDLE. pkt_len holds until the next rx_start. A zero-length packet is legal (pkt_len=0).
- ERR:
  - fix_error=1 for one cycle.
  - tail_side and pkt_len cleared to 0.
  - overflow is held.
  - Then IDLE.
  - rx_start arriving during ERR is ignored; the decoder must re-issue it.
- tail_side always equals the number of accepted bytes modulo 4 since the last clear.
- pkt_len never exceeds MAX_BYTES. Arithmetic is unsigned with no wrap.

## Timing
- byte_received at posedge N -> rcv_enq_word, wr_data and updated tail_side/pkt_len visible after posedge N+1. Latency is one cycle.
- Maximum rate is one byte per cycle. Back-to-back bytes produce back-to-back enqueues.
- rx_eop at N (state RECV) -> state DONE after N+1, pkt_done high N+1..N+2, IDLE after N+2.
- rx_error at N -> fix_error high for exactly one cycle (N+1..N+2). rcv_enq_word is 0 during that cycle.
- full is sampled in the same cycle as byte_received. The block never issues rcv_enq_word for a byte that saw full=1.
- Asynchronous reset mid-packet forces IDLE with all outputs 0. No fix_error is generated; the FIFO is reset by the same n_rst.

## Test plan
- Clean packet: rx_start, 5 bytes 0x11..0x15 one per cycle, then rx_eop -> 5 rcv_enq_word pulses carrying 0x11..0x15, tail_side sequence 1,2,3,0,1, pkt_done one cycle, pkt_len=5, fix_error never set.
- Lane wrap and length limit: rx_start, 64 bytes, then a 65th byte -> 64 enqueues, tail_side=0 after byte 64, 65th byte not enqueued, fix_error one cycle, pkt_len=0, busy=0 two cycles later.
- Overflow: rx_start, 3 bytes, 4th byte with full=1 -> 3 enqueues only, overflow=1, fix_error pulse, overflow stays 1 until the next rx_start clears it.
- Simultaneous events:
  - Byte with rx_eop in the same cycle -> byte enqueued, pkt_len counts it, pkt_done follows.
  - Byte with rx_error in the same cycle -> no enqueue, fix_error pulse.
- Abort and idle noise:
  - rx_start while in RECV after 2 bytes -> fix_error, return to IDLE.
  - Bytes and rx_eop while in IDLE -> no outputs change.
  - Zero-length packet (rx_start then rx_eop) -> pkt_done, pkt_len=0.
- Reset mid-packet: n_rst low after 2 bytes, asynchronously -> all outputs 0 immediately, state IDLE, no fix_error after release.
